// File: rtl/pc_fetch_ras_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ras_pkg
//  Description : Shared types and helpers for the fetch-stage next-PC unit.
//                npc_sel_t names the next-PC source; helper functions derive
//                the sequential increment and the RAS pointer width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_ras_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JALR   = 3'd2,
        NPC_RET    = 3'd3,
        NPC_TRAP   = 3'd4
    } npc_sel_t;

    // Sequential increment for 4-byte instructions.
    localparam int unsigned c_inc = 4;

    // Sequential increment for a given target alignment.
    function automatic int unsigned inc_of(input int unsigned align_bits);
        return 32'd1 << align_bits;
    endfunction

    // Pointer width needed to index a RAS of the given depth.
    function automatic int unsigned ras_ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ras_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ras_stack
//  Description : Return-address stack built as a circular buffer plus a top
//                pointer. Push when full overwrites the oldest entry; pop
//                when empty is ignored; push+pop replaces the top in place
//                (or behaves as a plain push when empty).
//  Ports       : clk, rst (sync, active-low), push, pop, push_data,
//                top (current top entry), count (saturating), empty
//  Revision    : 1.0 - initial release
// ============================================================================
module ras_stack
    import pc_fetch_ras_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_data,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         empty
);

    localparam int unsigned          c_ptr_w = ras_ptr_w(RAS_DEPTH);
    localparam logic [c_ptr_w:0]     c_full  = (c_ptr_w + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0]   r_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_top;
    logic [c_ptr_w:0]   r_count;

    logic               w_has;
    logic               w_do_push;
    logic               w_do_replace;
    logic               w_do_pop;
    logic [c_ptr_w-1:0] w_ptr_next;

    assign w_has        = (r_count != '0);
    // Depth is a power of two, so the pointer wraps naturally.
    assign w_ptr_next   = r_top + 1'b1;
    // Nothing moves while held in reset.
    assign w_do_push    = rst && push && (!pop || !w_has);
    assign w_do_replace = rst && push && pop && w_has;
    assign w_do_pop     = rst && pop && !push && w_has;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_ptr_next] <= push_data;
        end else if (w_do_replace) begin
            r_mem[r_top] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // First push lands in slot 0.
            r_top   <= '1;
            r_count <= '0;
        end else if (w_do_push) begin
            r_top <= w_ptr_next;
            if (r_count != c_full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_do_pop) begin
            r_top   <= r_top - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    assign top   = r_mem[r_top];
    assign count = r_count;
    assign empty = !w_has;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ras.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ras
//  Description : Fetch-stage program counter with next-PC select (sequential,
//                branch/JAL, JALR, return), stall, misaligned-target trap and
//                a return-address stack for call/return prediction.
//  Ports       : clk, rst (sync, active-low), stall, PCsrc, JUMPRT, call, ret,
//                ImmOp, Result -> PC, misalign, ras_empty, ras_count
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ras
    import pc_fetch_ras_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     RAS_DEPTH  = 4,
    parameter int unsigned     ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'('h80)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        PCsrc,
    input  logic                        JUMPRT,
    input  logic                        call,
    input  logic                        ret,
    input  logic [WIDTH-1:0]            ImmOp,
    input  logic [WIDTH-1:0]            Result,
    output logic [WIDTH-1:0]            PC,
    output logic                        misalign,
    output logic                        ras_empty,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);

    localparam logic [WIDTH-1:0] c_inc_w = WIDTH'(inc_of(ALIGN_BITS));

    logic [WIDTH-1:0] r_pc;
    logic             r_misalign;

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_branch;
    logic [WIDTH-1:0] w_jalr;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;
    logic [WIDTH-1:0] w_cand;
    logic             w_misaligned;
    npc_sel_t         w_sel;
    logic [WIDTH-1:0] w_next;
    logic             w_push;
    logic             w_pop;

    assign w_seq    = r_pc + c_inc_w;
    assign w_branch = r_pc + ImmOp;
    assign w_jalr   = Result & ~{{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        w_sel  = NPC_SEQ;
        w_cand = w_seq;
        if (PCsrc) begin
            if (!JUMPRT) begin
                w_sel  = NPC_BRANCH;
                w_cand = w_branch;
            end else if (ret && !w_ras_empty) begin
                w_sel  = NPC_RET;
                w_cand = w_ras_top;
            end else begin
                w_sel  = NPC_JALR;
                w_cand = w_jalr;
            end
        end
        // Only redirected targets are checked; sequential ones stay aligned.
        w_misaligned = PCsrc && (w_cand[ALIGN_BITS-1:0] != '0);
        if (w_misaligned) begin
            w_sel = NPC_TRAP;
        end
    end

    always_comb begin
        w_next = w_cand;
        case (w_sel)
            NPC_TRAP: w_next = TRAP_VEC;
            default:  w_next = w_cand;
        endcase
    end

    // A trapping redirect leaves the stack untouched.
    assign w_push = !stall && PCsrc && call && !w_misaligned;
    assign w_pop  = !stall && PCsrc && JUMPRT && ret && !w_misaligned;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_seq),
        .top       (w_ras_top),
        .count     (ras_count),
        .empty     (w_ras_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_pc       <= w_next;
            r_misalign <= (w_sel == NPC_TRAP);
        end
    end

    assign PC        = r_pc;
    assign misalign  = r_misalign;
    assign ras_empty = w_ras_empty;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ras.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_ras
//  Description : Directed self-checking bench for pc_fetch_ras. Each step
//                drives inputs, queues the expected post-edge state and
//                checks it #1 after the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ras;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        PCsrc;
    logic        JUMPRT;
    logic        call;
    logic        ret;
    logic [31:0] ImmOp;
    logic [31:0] Result;
    logic [31:0] PC;
    logic        misalign;
    logic        ras_empty;
    logic [2:0]  ras_count;

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
        logic [2:0]  cnt;
        logic        empty;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    pc_fetch_ras #(
        .WIDTH      (32),
        .RAS_DEPTH  (4),
        .ALIGN_BITS (2),
        .RESET_VEC  (32'h0),
        .TRAP_VEC   (32'h80)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .PCsrc     (PCsrc),
        .JUMPRT    (JUMPRT),
        .call      (call),
        .ret       (ret),
        .ImmOp     (ImmOp),
        .Result    (Result),
        .PC        (PC),
        .misalign  (misalign),
        .ras_empty (ras_empty),
        .ras_count (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input string tag,
                        input logic r, input logic s, input logic p,
                        input logic j, input logic c, input logic rt,
                        input logic [31:0] imm, input logic [31:0] res,
                        input logic [31:0] epc, input logic emis,
                        input logic [2:0] ecnt);
        exp_t e;
        rst = r; stall = s; PCsrc = p; JUMPRT = j; call = c; ret = rt;
        ImmOp = imm; Result = res;
        sb.push_back('{pc: epc, mis: emis, cnt: ecnt, empty: (ecnt == 3'd0)});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        assert (PC === e.pc) else begin
            n_mis++;
            $error("FAIL %s pc: observed %h expected %h", tag, PC, e.pc);
        end
        n_cmp++;
        assert (misalign === e.mis) else begin
            n_mis++;
            $error("FAIL %s misalign: observed %b expected %b", tag, misalign, e.mis);
        end
        n_cmp++;
        assert (ras_count === e.cnt) else begin
            n_mis++;
            $error("FAIL %s ras_count: observed %0d expected %0d", tag, ras_count, e.cnt);
        end
        n_cmp++;
        assert (ras_empty === e.empty) else begin
            n_mis++;
            $error("FAIL %s ras_empty: observed %b expected %b", tag, ras_empty, e.empty);
        end
    endtask

    // Arguments: tag, rst, stall, PCsrc, JUMPRT, call, ret, ImmOp, Result,
    //            expected PC, expected misalign, expected ras_count
    initial begin
        rst = 1'b0; stall = 1'b0; PCsrc = 1'b0; JUMPRT = 1'b0;
        call = 1'b0; ret = 1'b0; ImmOp = '0; Result = '0;

        // Reset and sequential fetch
        step("rst0",   0,0,0,0,0,0, 32'h0, 32'h0, 32'h0,   0, 3'd0);
        step("rst1",   0,0,0,0,0,0, 32'h0, 32'h0, 32'h0,   0, 3'd0);
        step("seq4",   1,0,0,0,0,0, 32'h0, 32'h0, 32'h4,   0, 3'd0);
        step("seq8",   1,0,0,0,0,0, 32'h0, 32'h0, 32'h8,   0, 3'd0);
        step("seqC",   1,0,0,0,0,0, 32'h0, 32'h0, 32'hC,   0, 3'd0);

        // Branch and stall
        step("jalr10", 1,0,1,1,0,0, 32'h0, 32'h10, 32'h10, 0, 3'd0);
        step("stallb", 1,1,1,0,0,0, 32'hFFFF_FFF8, 32'h0, 32'h10, 0, 3'd0);
        step("brneg8", 1,0,1,0,0,0, 32'hFFFF_FFF8, 32'h0, 32'h08, 0, 3'd0);

        // JALR masking and misaligned trap
        step("jalr41", 1,0,1,1,0,0, 32'h0, 32'h41, 32'h40, 0, 3'd0);
        step("jalr42", 1,0,1,1,0,0, 32'h0, 32'h42, 32'h80, 1, 3'd0);
        step("stallm", 1,1,0,0,0,0, 32'h0, 32'h0,  32'h80, 1, 3'd0);
        step("misclr", 1,0,0,0,0,0, 32'h0, 32'h0,  32'h84, 0, 3'd0);
        step("brmis",  1,0,1,0,0,0, 32'h2, 32'h0,  32'h80, 1, 3'd0);
        step("call80", 1,0,1,1,1,0, 32'h0, 32'h40, 32'h40, 0, 3'd1);
        step("callms", 1,0,1,1,1,0, 32'h0, 32'h46, 32'h80, 1, 3'd1);
        step("ret84",  1,0,1,1,0,1, 32'h0, 32'h43, 32'h84, 0, 3'd0);

        // Five calls into a 4-deep RAS, then five returns
        step("to100",  1,0,1,1,0,0, 32'h0, 32'h100, 32'h100, 0, 3'd0);
        step("call1",  1,0,1,1,1,0, 32'h0, 32'h200, 32'h200, 0, 3'd1);
        step("call2",  1,0,1,1,1,0, 32'h0, 32'h300, 32'h300, 0, 3'd2);
        step("call3",  1,0,1,1,1,0, 32'h0, 32'h400, 32'h400, 0, 3'd3);
        step("call4",  1,0,1,1,1,0, 32'h0, 32'h500, 32'h500, 0, 3'd4);
        step("call5",  1,0,1,1,1,0, 32'h0, 32'h600, 32'h600, 0, 3'd4);
        step("ret1",   1,0,1,1,0,1, 32'h0, 32'h701, 32'h504, 0, 3'd3);
        step("ret2",   1,0,1,1,0,1, 32'h0, 32'h701, 32'h404, 0, 3'd2);
        step("ret3",   1,0,1,1,0,1, 32'h0, 32'h701, 32'h304, 0, 3'd1);
        step("ret4",   1,0,1,1,0,1, 32'h0, 32'h701, 32'h204, 0, 3'd0);
        step("ret5",   1,0,1,1,0,1, 32'h0, 32'h701, 32'h700, 0, 3'd0);

        // call&ret together: replace top; on empty, push only
        step("to100b", 1,0,1,1,0,0, 32'h0, 32'h100, 32'h100, 0, 3'd0);
        step("call20", 1,0,1,1,1,0, 32'h0, 32'h20,  32'h20,  0, 3'd1);
        step("cr_rep", 1,0,1,1,1,1, 32'h0, 32'h999, 32'h104, 0, 3'd1);
        step("ret24",  1,0,1,1,0,1, 32'h0, 32'h0,   32'h24,  0, 3'd0);
        step("cr_emp", 1,0,1,1,1,1, 32'h0, 32'h30,  32'h30,  0, 3'd1);
        step("ret28",  1,0,1,1,0,1, 32'h0, 32'h0,   32'h28,  0, 3'd0);
        step("callnp", 1,0,0,0,1,0, 32'h0, 32'h0,   32'h2C,  0, 3'd0);

        // Reset during stall with a non-empty RAS
        step("call50", 1,0,1,1,1,0, 32'h0, 32'h50, 32'h50, 0, 3'd1);
        step("stall5", 1,1,0,0,0,0, 32'h0, 32'h0,  32'h50, 0, 3'd1);
        step("rststl", 0,1,0,0,0,0, 32'h0, 32'h0,  32'h0,  0, 3'd0);
        step("postrs", 1,0,0,0,0,0, 32'h0, 32'h0,  32'h4,  0, 3'd0);
        step("retclr", 1,0,1,1,0,1, 32'h0, 32'h61, 32'h60, 0, 3'd0);

        // Address-space wrap
        step("tohigh", 1,0,1,1,0,0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 3'd0);
        step("wrap",   1,0,0,0,0,0, 32'h0, 32'h0,         32'h0,         0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
